// File: rtl/lagarto0_pkg.sv
// Shared constants and types for the lagarto0 front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lagarto0_pkg;

  localparam int ICACHE_LINE_SIZE = 128;
  localparam int ADDR_SIZE        = 32;

  // Refill geometry derived from the line size.
  localparam int LINE_WORDS = ICACHE_LINE_SIZE / 32;
  localparam int OFS_BITS   = $clog2(ICACHE_LINE_SIZE / 8);
  localparam int IDX_BITS   = OFS_BITS - 2;
  localparam int CNT_BITS   = $clog2(LINE_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE
  } refill_state_e;

endpackage

// File: rtl/icache_refill.sv
// I-cache miss refill engine: fetches one line word-by-word, then writes it to the cache.
// Latency: miss sample to ic_we_o is 2*LINE_WORDS+1 cycles best case (one word in flight).
// Backpressure: mem_req_o/mem_addr_o held until mem_gnt_i; busy_o stalls fetch until WRITE ends.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   miss_i, miss_addr_i            fetch miss strobe and PC (sampled only when idle)
//   busy_o                         high whenever not idle
//   ic_we_o, ic_addr_o, ic_line_o  one-cycle line write into the cache
//   mem_req_o, mem_addr_o          word read request (held until granted)
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory grant and read response
//
// Build option: ICACHE_REFILL_CRITICAL_FIRST_EN starts the refill at the missing
// word and wraps; without it every refill starts at word 0.
module icache_refill
  import lagarto0_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        miss_i,
  input  logic [ADDR_SIZE-1:0]        miss_addr_i,
  output logic                        busy_o,
  output logic                        ic_we_o,
  output logic [ADDR_SIZE-1:0]        ic_addr_o,
  output logic [ICACHE_LINE_SIZE-1:0] ic_line_o,
  output logic                        mem_req_o,
  output logic [ADDR_SIZE-1:0]        mem_addr_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [31:0]                 mem_rdata_i
);

  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(LINE_WORDS - 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(LINE_WORDS - 1);

  refill_state_e                   state_q, state_d;
  // Only the line-aligned part of the address is kept; offset bits are always zero.
  logic [ADDR_SIZE-OFS_BITS-1:0]   base_q, base_d;
  logic [IDX_BITS-1:0]             idx_q, idx_d;
  logic [CNT_BITS-1:0]             cnt_q, cnt_d;
  logic [ICACHE_LINE_SIZE-1:0]     line_q, line_d;

  logic [IDX_BITS-1:0]             start_idx;
  logic [IDX_BITS-1:0]             idx_next;
  logic                            unused_ofs;

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  assign start_idx = miss_addr_i[OFS_BITS-1:2];
`else
  assign start_idx = '0;
`endif

  // Offset bits of the miss PC are irrelevant to the line address.
  assign unused_ofs = ^miss_addr_i[OFS_BITS-1:0];

  // Explicit wrap keeps the index correct even if LINE_WORDS is not 2**IDX_BITS.
  assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_BITS'(1);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    busy_o    = 1'b1;
    ic_we_o   = 1'b0;
    mem_req_o = 1'b0;

    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (miss_i) begin
          base_d  = miss_addr_i[ADDR_SIZE-1:OFS_BITS];
          idx_d   = start_idx;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (mem_rvalid_i) begin
          line_d[{idx_q, 5'b0} +: 32] = mem_rdata_i;
          cnt_d = cnt_q + CNT_BITS'(1);
          // The counter, not the index, decides completion, so a wrapped
          // critical-word-first sequence still collects every word.
          if (cnt_q == CNT_LAST) begin
            state_d = WRITE;
          end else begin
            idx_d   = idx_next;
            state_d = REQ;
          end
        end
      end

      WRITE: begin
        ic_we_o = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  assign ic_addr_o  = {base_q, OFS_BITS'(0)};
  assign ic_line_o  = line_q;
  assign mem_addr_o = {base_q, idx_q, 2'b00};

endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;
  import lagarto0_pkg::*;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic                        miss_i;
  logic [ADDR_SIZE-1:0]        miss_addr_i;
  logic                        busy_o;
  logic                        ic_we_o;
  logic [ADDR_SIZE-1:0]        ic_addr_o;
  logic [ICACHE_LINE_SIZE-1:0] ic_line_o;
  logic                        mem_req_o;
  logic [ADDR_SIZE-1:0]        mem_addr_o;
  logic                        mem_gnt_i;
  logic                        mem_rvalid_i;
  logic [31:0]                 mem_rdata_i;

  always #5 clk_i = ~clk_i;

  icache_refill dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .miss_i       (miss_i),
    .miss_addr_i  (miss_addr_i),
    .busy_o       (busy_o),
    .ic_we_o      (ic_we_o),
    .ic_addr_o    (ic_addr_o),
    .ic_line_o    (ic_line_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int rv_count = 0;
  int we_count = 0;
  bit pending = 0;
  bit spur = 0;
  logic [31:0]  pend_data;
  logic [31:0]  ea, wa;
  logic [127:0] wl;
  logic [127:0] last_line = '0;

  // Scoreboard queues: filled when a miss is driven, drained as the DUT acts.
  logic [31:0]  exp_req_q[$];
  logic [31:0]  exp_waddr_q[$];
  logic [127:0] exp_line_q[$];

  always @(posedge clk_i) cyc = cyc + 1;

  // Memory word contents: line 0x1000 holds A0..A3, other lines are distinct.
  function automatic logic [31:0] word_data(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'b0};
    return (b ^ 32'h1000) | (32'hA0 + 32'(a[3:2]));
  endfunction

  function automatic void push_refill(input logic [31:0] a);
    logic [31:0]  b;
    logic [127:0] ln;
    int s;
    b = {a[31:4], 4'b0};
    s = 0;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
    s = int'(a[3:2]);
`endif
    for (int i = 0; i < 4; i++) exp_req_q.push_back(b | (32'((s + i) % 4) << 2));
    for (int i = 0; i < 4; i++) ln[i*32 +: 32] = word_data(b | 32'(i * 4));
    exp_waddr_q.push_back(b);
    exp_line_q.push_back(ln);
    last_line = ln;
  endfunction

  // Memory responder and write monitor, active 1ns after each rising edge.
  always @(posedge clk_i) begin
    #1;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (ic_we_o === 1'b1) begin
      we_count++;
      checks++;
      if (exp_waddr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h, required no write", ic_addr_o);
      end else begin
        wa = exp_waddr_q.pop_front();
        wl = exp_line_q.pop_front();
        if (ic_addr_o !== wa) begin
          errors++;
          $display("FAIL write_addr got %h required %h", ic_addr_o, wa);
        end
        checks++;
        if (ic_line_o !== wl) begin
          errors++;
          $display("FAIL write_line got %h required %h", ic_line_o, wl);
        end
      end
    end
    if (spur) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD;
      spur = 0;
    end else if (pending) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = pend_data;
      pending = 0;
      rv_count++;
    end else if (mem_req_o === 1'b1) begin
      checks++;
      if (exp_req_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req got addr=%h, required no request", mem_addr_o);
      end else if (stall_cnt > 0) begin
        if (mem_addr_o !== exp_req_q[0]) begin
          errors++;
          $display("FAIL req_stable got %h required %h", mem_addr_o, exp_req_q[0]);
        end
        stall_cnt--;
      end else begin
        ea = exp_req_q.pop_front();
        if (mem_addr_o !== ea) begin
          errors++;
          $display("FAIL req_addr got %h required %h", mem_addr_o, ea);
        end
        mem_gnt_i = 1'b1;
        pending   = 1;
        pend_data = word_data(mem_addr_o);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_miss(input logic [31:0] a, output int t0);
    step();
    miss_i      = 1'b1;
    miss_addr_i = a;
    t0          = cyc;
    push_refill(a);
    step();
    miss_i = 1'b0;
  endtask

  task automatic wait_we(input int t0, input int exp_lat, input string name);
    int n = 0;
    while (ic_we_o !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (ic_we_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout got no ic_we_o, required one within 100 cycles", name);
    end else if (cyc - t0 != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d required %0d", name, cyc - t0, exp_lat);
    end
  endtask

  task automatic check_idle_zero(input string name, input logic [127:0] exp_line);
    checks++;
    if (busy_o !== 1'b0 || ic_we_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl got busy=%b we=%b req=%b required 0 0 0", name, busy_o, ic_we_o, mem_req_o);
    end
    checks++;
    if (ic_line_o !== exp_line) begin
      errors++;
      $display("FAIL %s_line got %h required %h", name, ic_line_o, exp_line);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    miss_i = 1'b0;
    miss_addr_i = '0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    #12;
    check_idle_zero("reset", '0);
    checks++;
    if (ic_addr_o !== '0 || mem_addr_o !== '0) begin
      errors++;
      $display("FAIL reset_addr got ic=%h mem=%h required 0 0", ic_addr_o, mem_addr_o);
    end
    #10 rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    int t0;
    int w0;
    w0 = we_count;
    do_miss(32'h0000_1008, t0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b required 1", busy_o);
    end
    wait_we(t0, 2 * LINE_WORDS + 1, "basic");
    step();
    checks++;
    if (ic_we_o !== 1'b0 || busy_o !== 1'b0 || we_count != w0 + 1) begin
      errors++;
      $display("FAIL basic_one_pulse got we=%b busy=%b writes=%0d required 0 0 %0d", ic_we_o, busy_o, we_count - w0, 1);
    end
  endtask

  task automatic test_spurious();
    spur = 1;
    step();
    step();
    step();
    check_idle_zero("spurious", last_line);
  endtask

  task automatic test_grant_stall();
    int t0;
    stall_cnt = 5;
    do_miss(32'h0000_1000, t0);
    wait_we(t0, 2 * LINE_WORDS + 1 + 5, "stall");
    checks++;
    if (stall_cnt != 0) begin
      errors++;
      $display("FAIL stall_cycles got %0d unused stalls required 0", stall_cnt);
    end
  endtask

  task automatic test_miss_while_busy();
    int t0;
    int w0;
    w0 = we_count;
    do_miss(32'h0000_1000, t0);
    step();
    miss_i      = 1'b1;
    miss_addr_i = 32'h0000_2000;
    step();
    miss_i = 1'b0;
    wait_we(t0, 2 * LINE_WORDS + 1, "busy_miss");
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (we_count != w0 + 1 || exp_req_q.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_miss_ignored got writes=%0d reqs_left=%0d busy=%b required 1 0 0", we_count - w0, exp_req_q.size(), busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    int w0;
    int n = 0;
    rv_count = 0;
    do_miss(32'h0000_3000, t0);
    while (rv_count < 2 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (rv_count < 2) begin
      errors++;
      $display("FAIL rstmid_progress got %0d words required 2", rv_count);
    end
    step();
    w0 = we_count;
    #1 rst_ni = 1'b0;
    #1;
    check_idle_zero("rstmid_async", '0);
    checks++;
    if (ic_addr_o !== '0 || mem_addr_o !== '0) begin
      errors++;
      $display("FAIL rstmid_addr got ic=%h mem=%h required 0 0", ic_addr_o, mem_addr_o);
    end
    exp_req_q.delete();
    exp_waddr_q.delete();
    exp_line_q.delete();
    pending = 0;
    step();
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (we_count != w0) begin
      errors++;
      $display("FAIL rstmid_no_write got %0d writes required 0", we_count - w0);
    end
    check_idle_zero("rstmid_after", '0);
  endtask

  task automatic test_back_to_back();
    int t0;
    do_miss(32'h0000_4004, t0);
    wait_we(t0, 2 * LINE_WORDS + 1, "b2b_first");
    do_miss(32'h0000_5000, t0);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b required 1", busy_o);
    end
    wait_we(t0, 2 * LINE_WORDS + 1, "b2b_second");
    step();
    checks++;
    if (exp_waddr_q.size() != 0 || exp_req_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain got writes_left=%0d reqs_left=%0d required 0 0", exp_waddr_q.size(), exp_req_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spurious();
    test_grant_stall();
    test_miss_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Miss-handling refill engine for the L1 instruction cache: the write-side counterpart of the cache's read port used by the fetch stage. On a fetch miss it captures the missing PC, reads the full cache line from backing memory one 32-bit word at a time over a request/grant/valid bus, assembles it, and drives the cache's write port (`we_i`, `inst_i`) with the completed line for one cycle. It sits between `icache` and the memory interface, alongside the fetch stage.

## Interface
Parameters (package constants, not overridable per instance):
- `ICACHE_LINE_SIZE`, 128: line width in bits; must be a power-of-two multiple of 32.
- `ADDR_SIZE`, 32: address width.
- `LINE_WORDS`, `ICACHE_LINE_SIZE/32` (4): words per line.
- `OFS_BITS`, `$clog2(ICACHE_LINE_SIZE/8)` (4): byte-offset bits within a line.

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_ni` in 1: asynchronous, active-low reset.
- `miss_i` in 1: fetch missed in cache this cycle.
- `miss_addr_i` in ADDR_SIZE: PC of the missing fetch.
- `busy_o` out 1: refill in progress; fetch holds PC.
- `ic_we_o` out 1: one-cycle write strobe to `icache.we_i`.
- `ic_addr_o` out ADDR_SIZE: line-aligned write address.
- `ic_line_o` out ICACHE_LINE_SIZE: assembled line to `icache.inst_i`.
- `mem_req_o` out 1: word read request.
- `mem_addr_o` out ADDR_SIZE: word-aligned request address.
- `mem_gnt_i` in 1: request accepted this cycle.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in 32: read data.

## Operation
- FSM states: IDLE, REQ, WAIT, WRITE.
- IDLE: when `miss_i`=1, capture `miss_addr_i` into the base register with the low OFS_BITS cleared, and set the word index to the start word. Next state is REQ. `busy_o`=0 only in IDLE.
- REQ: `mem_req_o`=1 and `mem_addr_o`=base | (index<<2). `mem_req_o` and `mem_addr_o` stay stable until `mem_gnt_i`=1. On grant, go to WAIT.
- WAIT: on `mem_rvalid_i`, write `mem_rdata_i` into line slot `[index*32 +: 32]` and increment the counter.
  - If all LINE_WORDS words have been received, go to WRITE.
  - Otherwise, advance the index and go to REQ.
- WRITE: `ic_we_o`=1 for exactly one cycle, with `ic_addr_o`=base and `ic_line_o`=the assembled line. Then return to IDLE.
- Only one request is outstanding at a time. `mem_rvalid_i` outside WAIT is ignored.
- `miss_i` is ignored in every state except IDLE.
- Index arithmetic is modulo LINE_WORDS: the index wraps from LINE_WORDS-1 to 0.
- A separate word counter (0..LINE_WORDS) decides completion, independent of the start index.

## Timing
- Reset values: the FSM is in IDLE and all outputs are 0. The line buffer, base register, index and counter are all cleared.
- Reset asserted mid-refill aborts immediately: the partial line is discarded and no `ic_we_o` is issued.
- `mem_req_o` rises in the cycle after `miss_i` is sampled.
- The bus guarantees that `mem_rvalid_i` never arrives in the same cycle as `mem_gnt_i`. The earliest arrival is the cycle after grant.
- The next `mem_req_o` rises in the cycle after `mem_rvalid_i`.
- Best-case latency (grant in the first REQ cycle, rvalid in the first WAIT cycle): from `miss_i` sample to `ic_we_o` is 2*LINE_WORDS+1 cycles (9 for 128-bit lines).
- A new miss can be accepted in the cycle after WRITE.
- All outputs are registered or decoded directly from state and registers. There is no combinational path from any input to any output.

## Configuration
- Macro: `ICACHE_REFILL_CRITICAL_FIRST_EN`.
- Defined: the start index is `miss_addr_i[OFS_BITS-1:2]` (critical word first). Subsequent words wrap modulo LINE_WORDS.
- Undefined: the start index is always 0, so words are fetched in ascending order.
- Either way, the final line is identical, and `ic_we_o` fires only after all words have arrived.

## Structure
- In `lagarto0_pkg`: `LINE_WORDS`, `OFS_BITS`, and the state enum `refill_state_e` (IDLE, REQ, WAIT, WRITE). `ICACHE_LINE_SIZE` and `ADDR_SIZE` are already defined there.
- Single module with no sub-modules. The line buffer is a flat register with an indexed-part-select write.

## Test plan
- Basic refill: miss at 0x0000_1008 with grant and rvalid immediate, data 0xA0..0xA3 per word.
  - Without the macro: requests to 0x1000, 1004, 1008, 100C.
  - `ic_we_o` fires 9 cycles after the miss with `ic_addr_o`=0x1000 and line {A3,A2,A1,A0}.
- Critical first (macro defined): miss at 0x0000_1008 → request order 0x1008, 100C, 1000, 1004. The line is identical to the previous case.
- Grant stall: hold `mem_gnt_i`=0 for 5 cycles in the first REQ → `mem_req_o` and `mem_addr_o` stay stable for all 6 cycles; `ic_we_o` is delayed by exactly 5 cycles.
- Miss while busy: pulse `miss_i` with 0x2000 during WAIT → it is ignored; the refill completes for 0x1000 only, and exactly one `ic_we_o` is issued.
- Reset mid-refill: assert `rst_ni`=0 after 2 words are received → all outputs go to 0 asynchronously; after release, the block is in IDLE and no `ic_we_o` appears.
- Spurious data: `mem_rvalid_i`=1 in IDLE with data 0xDEAD → the line buffer is unchanged and the FSM stays in IDLE.
